interrupt_controller: RTL and testbench

- Drives the fetch unit's interrupt handler interface; it is the requesting end of the protocol the fetch unit consumes.
- Edge-detects external interrupt lines and latches them as pending.
- Applies a software-written enable mask and picks the highest-priority pending source.
- Presents a vector to the fetch unit and tracks the interrupt until the CPU executes return-from-interrupt.

---
 rtl/nand_cpu_pkg.sv | 29 ++
 rtl/interrupt_controller_priority_enc.sv | 24 ++
 rtl/interrupt_controller.sv | 166 ++++++++++++++++
 tb/tb_interrupt_controller.sv | 227 ++++++++++++++++++++++
 4 files changed

// File: rtl/nand_cpu_pkg.sv
// Shared CPU package: PC width, interrupt-controller state and defaults.
// PC_SIZE normally comes from nand_cpu.svh; a fallback keeps this slice standalone.
`ifndef PC_SIZE
`define PC_SIZE 16
`endif

package nand_cpu_pkg;

  localparam int unsigned PC_W             = `PC_SIZE;
  localparam int unsigned INTC_ID_W        = 4;
  localparam int unsigned INTC_VECTOR_BASE = 32'h10;
  localparam int unsigned INTC_VEC_STRIDE  = 4;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    REQ     = 2'd1,
    SERVICE = 2'd2
  } intc_state_t;

  // Handler PC for a source id, wrapping to the PC width.
  function automatic logic [PC_W-1:0] intc_vector(input int unsigned base,
                                                  input int unsigned stride,
                                                  input logic [INTC_ID_W-1:0] id);
    int unsigned full;
    full = base + (32'(id) * stride);
    return PC_W'(full);
  endfunction

endpackage

// File: rtl/interrupt_controller_priority_enc.sv
// Lowest-index-first priority encoder for the interrupt controller.
module intc_priority_enc
  import nand_cpu_pkg::*;
#(
  parameter int unsigned N = 4
) (
  input  logic [N-1:0]         req_i,
  output logic                 valid_c,
  output logic [INTC_ID_W-1:0] idx_c
);

  // Scan high to low so the lowest set index is the last one written.
  always_comb begin
    valid_c = 1'b0;
    idx_c   = '0;
    for (int i = int'(N) - 1; i >= 0; i--) begin
      if (req_i[i]) begin
        valid_c = 1'b1;
        idx_c   = INTC_ID_W'(i);
      end
    end
  end

endmodule

// File: rtl/interrupt_controller.sv
// Interrupt controller: edge-detects irq lines, masks, prioritises and
// hands one interrupt at a time to the fetch unit until return-from-interrupt.
// Optional feature macro: INTC_WAKE_EN (halt-release wake pulse).
module interrupt_controller
  import nand_cpu_pkg::*;
#(
  parameter int unsigned NUM_IRQ     = 4,
  parameter int unsigned VECTOR_BASE = INTC_VECTOR_BASE,
  parameter int unsigned VEC_STRIDE  = INTC_VEC_STRIDE
) (
  input  logic                 clk,
  input  logic                 n_rst,
  input  logic [NUM_IRQ-1:0]   irq_in,
  input  logic                 en_we,
  input  logic [15:0]          en_wdata,
  input  logic                 int_ack,
  input  logic                 int_return,
  input  logic                 halted,
  output logic                 int_req,
  output logic [PC_W-1:0]      int_vector,
  output logic [INTC_ID_W-1:0] active_id,
  output logic                 in_service,
  output logic [NUM_IRQ-1:0]   pending,
  output logic                 wake
);

  intc_state_t          state_q, state_d;
  logic [NUM_IRQ-1:0]   prev_q;
  logic [NUM_IRQ-1:0]   pending_q, pending_d;
  logic [NUM_IRQ-1:0]   mask_q, mask_d;
  logic                 int_req_q, int_req_d;
  logic [PC_W-1:0]      vector_q, vector_d;
  logic [INTC_ID_W-1:0] active_id_q, active_id_d;
  logic                 in_service_q, in_service_d;

  logic [NUM_IRQ-1:0]   edge_c;
  logic [NUM_IRQ-1:0]   eligible_c;
  logic [NUM_IRQ-1:0]   ack_clr_c;
  logic                 sel_valid_c;
  logic [INTC_ID_W-1:0] sel_idx_c;

  // Upper enable bits are don't-care; halted only matters with the wake feature.
  logic unused_in_c;
  assign unused_in_c = ^{en_wdata, halted};

  assign edge_c     = irq_in & ~prev_q;
  assign eligible_c = pending_q & mask_q;

  intc_priority_enc #(
    .N (NUM_IRQ)
  ) u_prio (
    .req_i   (eligible_c),
    .valid_c (sel_valid_c),
    .idx_c   (sel_idx_c)
  );

  // Next-state for pending, mask and the request/service FSM.
  always_comb begin
    state_d      = state_q;
    int_req_d    = int_req_q;
    vector_d     = vector_q;
    active_id_d  = active_id_q;
    in_service_d = in_service_q;
    mask_d       = mask_q;
    ack_clr_c    = '0;

    if (en_we) begin
      mask_d = en_wdata[NUM_IRQ-1:0];
    end

    case (state_q)
      IDLE: begin
        if (sel_valid_c) begin
          state_d     = REQ;
          int_req_d   = 1'b1;
          active_id_d = sel_idx_c;
          vector_d    = intc_vector(VECTOR_BASE, VEC_STRIDE, sel_idx_c);
        end
      end
      REQ: begin
        if (int_ack) begin
          state_d      = SERVICE;
          int_req_d    = 1'b0;
          in_service_d = 1'b1;
          ack_clr_c    = NUM_IRQ'(1) << active_id_q;
        end
      end
      SERVICE: begin
        if (int_return) begin
          state_d      = IDLE;
          in_service_d = 1'b0;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    // A fresh edge wins over the acknowledge clear.
    pending_d = (pending_q & ~ack_clr_c) | edge_c;
  end

  // State registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!n_rst) begin
      state_q      <= IDLE;
      prev_q       <= '0;
      pending_q    <= '0;
      mask_q       <= '0;
      int_req_q    <= 1'b0;
      vector_q     <= '0;
      active_id_q  <= '0;
      in_service_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      prev_q       <= irq_in;
      pending_q    <= pending_d;
      mask_q       <= mask_d;
      int_req_q    <= int_req_d;
      vector_q     <= vector_d;
      active_id_q  <= active_id_d;
      in_service_q <= in_service_d;
    end
  end

`ifdef INTC_WAKE_EN
  logic wake_q, wake_d;
  logic armed_q, armed_d;
  logic any_elig_c;

  assign any_elig_c = |eligible_c;

  // One wake pulse per halted-with-eligible episode.
  always_comb begin
    wake_d  = halted & any_elig_c & armed_q;
    armed_d = armed_q;
    if (!halted || !any_elig_c) begin
      armed_d = 1'b1;
    end else if (wake_d) begin
      armed_d = 1'b0;
    end
  end

  // Wake pulse and re-arm registers.
  always_ff @(posedge clk) begin
    if (!n_rst) begin
      wake_q  <= 1'b0;
      armed_q <= 1'b1;
    end else begin
      wake_q  <= wake_d;
      armed_q <= armed_d;
    end
  end

  assign wake = wake_q;
`else
  assign wake = 1'b0;
`endif

  assign int_req    = int_req_q;
  assign int_vector = vector_q;
  assign active_id  = active_id_q;
  assign in_service = in_service_q;
  assign pending    = pending_q;

endmodule

// File: tb/tb_interrupt_controller.sv
// Directed self-checking bench for interrupt_controller (default parameters).
module tb_interrupt_controller;

  localparam int unsigned NIRQ = 4;
  localparam int unsigned PCW  = nand_cpu_pkg::PC_W;

  logic            clk = 1'b0;
  logic            n_rst;
  logic [NIRQ-1:0] irq_in;
  logic            en_we;
  logic [15:0]     en_wdata;
  logic            int_ack;
  logic            int_return;
  logic            halted;
  logic            int_req;
  logic [PCW-1:0]  int_vector;
  logic [3:0]      active_id;
  logic            in_service;
  logic [NIRQ-1:0] pending;
  logic            wake;

  int n_cmp = 0;
  int n_bad = 0;

  interrupt_controller #(
    .NUM_IRQ     (NIRQ),
    .VECTOR_BASE (32'h10),
    .VEC_STRIDE  (4)
  ) dut (
    .clk        (clk),
    .n_rst      (n_rst),
    .irq_in     (irq_in),
    .en_we      (en_we),
    .en_wdata   (en_wdata),
    .int_ack    (int_ack),
    .int_return (int_return),
    .halted     (halted),
    .int_req    (int_req),
    .int_vector (int_vector),
    .active_id  (active_id),
    .in_service (in_service),
    .pending    (pending),
    .wake       (wake)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 'h%0h expected 'h%0h", tag, got, exp);
    end
  endtask

  // Advance n clock edges; outputs are stable 1 time unit after the edge.
  task automatic step(input int n);
    for (int k = 0; k < n; k++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic write_mask(input logic [15:0] m);
    en_we = 1'b1; en_wdata = m;
    step(1);
    en_we = 1'b0;
  endtask

  task automatic pulse_ack();
    int_ack = 1'b1; step(1); int_ack = 1'b0;
  endtask

  task automatic pulse_ret();
    int_return = 1'b1; step(1); int_return = 1'b0;
  endtask

  initial begin
    n_rst = 1'b0; irq_in = '0; en_we = 1'b0; en_wdata = '0;
    int_ack = 1'b0; int_return = 1'b0; halted = 1'b0;
    step(2);
    check("rst_req",     32'(int_req), 32'd0);
    check("rst_pend",    32'(pending), 32'd0);
    check("rst_svc",     32'(in_service), 32'd0);
    check("rst_id",      32'(active_id), 32'd0);
    check("rst_vec",     32'(int_vector), 32'd0);
    check("rst_wake",    32'(wake), 32'd0);

    // Single source: edge -> pending next cycle -> request the cycle after.
    n_rst = 1'b1;
    write_mask(16'h0001);
    irq_in = 4'b0001;
    step(1);
    check("t1_pend",     32'(pending), 32'h1);
    check("t1_noreq",    32'(int_req), 32'd0);
    step(1);
    irq_in = 4'b0000;
    check("t1_req",      32'(int_req), 32'd1);
    check("t1_vec",      32'(int_vector), 32'h10);
    check("t1_id",       32'(active_id), 32'd0);
    pulse_ack();
    check("t1_ack_req",  32'(int_req), 32'd0);
    check("t1_ack_svc",  32'(in_service), 32'd1);
    check("t1_ack_pend", 32'(pending), 32'd0);
    pulse_ret();
    check("t1_ret_svc",  32'(in_service), 32'd0);

    // Two simultaneous edges: lowest index first, then the other after return.
    write_mask(16'h000F);
    irq_in = 4'b1010;
    step(1);
    irq_in = 4'b0000;
    check("t2_pend",     32'(pending), 32'hA);
    step(1);
    check("t2_req",      32'(int_req), 32'd1);
    check("t2_id",       32'(active_id), 32'd1);
    check("t2_vec",      32'(int_vector), 32'h14);
    pulse_ack();
    check("t2_ack_pend", 32'(pending), 32'h8);
    check("t2_svc_noreq", 32'(int_req), 32'd0);
    pulse_ret();
    check("t2_gap_req",  32'(int_req), 32'd0);
    step(1);
    check("t2_req3",     32'(int_req), 32'd1);
    check("t2_id3",      32'(active_id), 32'd3);
    check("t2_vec3",     32'(int_vector), 32'h1C);
    pulse_ack();
    pulse_ret();
    step(1);
    check("t2_idle",     32'(int_req), 32'd0);

    // Masked source stays pending until enabled.
    write_mask(16'h0000);
    irq_in = 4'b0100;
    step(1);
    irq_in = 4'b0000;
    step(3);
    check("t3_noreq",    32'(int_req), 32'd0);
    check("t3_pend",     32'(pending), 32'h4);
    write_mask(16'h0004);
    check("t3_wr_noreq", 32'(int_req), 32'd0);
    step(1);
    check("t3_req",      32'(int_req), 32'd1);
    check("t3_id",       32'(active_id), 32'd2);
    check("t3_vec",      32'(int_vector), 32'h18);

    // Higher-priority arrival while requesting does not preempt.
    irq_in = 4'b0001; en_we = 1'b1; en_wdata = 16'h0005;
    step(1);
    irq_in = 4'b0000; en_we = 1'b0;
    check("t4_pend",     32'(pending), 32'h5);
    step(1);
    check("t4_hold_id",  32'(active_id), 32'd2);
    check("t4_hold_req", 32'(int_req), 32'd1);
    pulse_ack();
    check("t4_ack_pend", 32'(pending), 32'h1);
    pulse_ret();
    step(1);
    check("t4_req0",     32'(int_req), 32'd1);
    check("t4_id0",      32'(active_id), 32'd0);
    check("t4_vec0",     32'(int_vector), 32'h10);

    // Edge on the acknowledged line in the ack cycle keeps it pending.
    write_mask(16'h000F);
    pulse_ack();
    pulse_ret();
    irq_in = 4'b0010;
    step(1);
    irq_in = 4'b0000;
    step(1);
    check("t5_id1",      32'(active_id), 32'd1);
    irq_in = 4'b0010; int_ack = 1'b1;
    step(1);
    irq_in = 4'b0000; int_ack = 1'b0;
    check("t5_pend",     32'(pending), 32'h2);
    check("t5_svc",      32'(in_service), 32'd1);
    pulse_ret();
    step(1);
    check("t5_rereq",    32'(int_req), 32'd1);
    check("t5_reid",     32'(active_id), 32'd1);

    // Reset in service abandons everything, mask included.
    pulse_ack();
    irq_in = 4'b0100;
    step(1);
    irq_in = 4'b0000;
    check("t6_svc",      32'(in_service), 32'd1);
    check("t6_pend",     32'(pending), 32'h4);
    n_rst = 1'b0;
    irq_in = 4'b0001;
    step(1);
    check("t6_rst_req",  32'(int_req), 32'd0);
    check("t6_rst_svc",  32'(in_service), 32'd0);
    check("t6_rst_pend", 32'(pending), 32'd0);
    // Line held high through reset release counts as an edge; mask is zero.
    n_rst = 1'b1;
    step(1);
    check("t6_held_pend", 32'(pending), 32'h1);
    step(2);
    check("t6_masked",   32'(int_req), 32'd0);
    irq_in = 4'b0000;

    // Wake pulse for a halted CPU.
    n_rst = 1'b0; step(1); n_rst = 1'b1;
    write_mask(16'h0002);
    halted = 1'b1;
    irq_in = 4'b0010;
    step(1);
    irq_in = 4'b0000;
    check("t7_wake_pre", 32'(wake), 32'd0);
    step(1);
`ifdef INTC_WAKE_EN
    check("t7_wake",     32'(wake), 32'd1);
`else
    check("t7_wake",     32'(wake), 32'd0);
`endif
    step(1);
    check("t7_wake_end", 32'(wake), 32'd0);
    step(2);
    check("t7_wake_once", 32'(wake), 32'd0);
    halted = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
